// File: rtl/axis_burst_reader_pkg.sv
// Shared types and default widths for the AXIS burst reader.
package axis_burst_reader_pkg;

    localparam int unsigned DEF_TDATA_WIDTH    = 128;
    localparam int unsigned DEF_LEN_WIDTH      = 32;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/axis_burst_reader_skid.sv
// Two-entry registered skid buffer: output register plus one overflow slot,
// so the upstream ready depends only on flops and full throughput is kept.
module axis_skid_buffer #(
    parameter int unsigned WIDTH = 129
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             empty
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             push;
    logic             pop;

    assign s_ready = !skid_valid_q;
    assign m_valid = out_valid_q;
    assign m_data  = out_data_q;
    assign empty   = !out_valid_q && !skid_valid_q;
    assign push    = s_valid && !skid_valid_q;
    assign pop     = out_valid_q && m_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!out_valid_q || pop) begin
            // The overflow slot is always older than anything arriving now.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (push) begin
                out_valid_d = 1'b1;
                out_data_d  = s_data;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (push) begin
            skid_valid_d = 1'b1;
            skid_data_d  = s_data;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/axis_burst_reader.sv
// Reads exactly burst_len beats from a FIFO AXIS port and forwards them with TLAST on the final beat.
// Optional stall timeout is compiled in when AXIS_BURST_READER_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | reading beats from the FIFO
// DRAIN | all reads issued, emptying the skid buffer
// DONE  | one-cycle done pulse
module axis_burst_reader
    import axis_burst_reader_pkg::*;
#(
    parameter int unsigned TDATA_WIDTH    = DEF_TDATA_WIDTH,
    parameter int unsigned LEN_WIDTH      = DEF_LEN_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   start,
    input  logic [LEN_WIDTH-1:0]   burst_len,
    output logic                   busy,
    output logic                   done,
    output logic [LEN_WIDTH-1:0]   beat_count,
    output logic                   timeout,
    input  logic [TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                   S_AXIS_TVALID,
    output logic                   S_AXIS_TREADY,
    output logic [TDATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                   M_AXIS_TVALID,
    output logic                   M_AXIS_TLAST,
    input  logic                   M_AXIS_TREADY
);

    state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
    logic [LEN_WIDTH-1:0]   beat_count_q, beat_count_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   skid_ready;
    logic                   skid_empty;
    logic                   in_hs;
    logic                   out_hs;
    logic [TDATA_WIDTH:0]   skid_out;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign S_AXIS_TREADY = (state_q == ST_RUN) && (remaining_q != '0) && skid_ready;
    assign in_hs         = S_AXIS_TVALID && S_AXIS_TREADY;
    assign out_hs        = M_AXIS_TVALID && M_AXIS_TREADY;

    axis_skid_buffer #(
        .WIDTH (TDATA_WIDTH + 1)
    ) u_skid (
        .aclk    (aclk),
        .areset  (areset),
        .s_data  ({S_AXIS_TDATA, remaining_q == LEN_WIDTH'(1)}),
        .s_valid (in_hs),
        .s_ready (skid_ready),
        .m_data  (skid_out),
        .m_valid (M_AXIS_TVALID),
        .m_ready (M_AXIS_TREADY),
        .empty   (skid_empty)
    );

    assign M_AXIS_TDATA = skid_out[TDATA_WIDTH:1];
    assign M_AXIS_TLAST = skid_out[0];
    assign busy         = busy_q;
    assign done         = done_q;
    assign beat_count   = beat_count_q;

`ifdef AXIS_BURST_READER_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_LOAD = STALL_W'(TIMEOUT_CYCLES - 1);

    logic               timeout_q, timeout_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        beat_count_d = beat_count_q;
`ifdef AXIS_BURST_READER_TIMEOUT_EN
        timeout_d    = timeout_q;
        stall_d      = stall_q;
`endif
        if (out_hs) begin
            beat_count_d = beat_count_q + LEN_WIDTH'(1);
        end
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    remaining_d  = burst_len;
                    beat_count_d = '0;
                    state_d      = (burst_len == '0) ? ST_DONE : ST_RUN;
`ifdef AXIS_BURST_READER_TIMEOUT_EN
                    timeout_d    = 1'b0;
                    stall_d      = STALL_LOAD;
`endif
                end
            end
            ST_RUN: begin
                if (in_hs) begin
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d = ST_DRAIN;
                    end
`ifdef AXIS_BURST_READER_TIMEOUT_EN
                    stall_d = STALL_LOAD;
                end else if (S_AXIS_TREADY && !S_AXIS_TVALID) begin
                    // Stall limit reached: stop reading, deliver what is already buffered.
                    if (stall_q == '0) begin
                        timeout_d = 1'b1;
                        state_d   = ST_DRAIN;
                    end else begin
                        stall_d = stall_q - STALL_W'(1);
                    end
`endif
                end
            end
            ST_DRAIN: begin
                if (skid_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            beat_count_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef AXIS_BURST_READER_TIMEOUT_EN
            timeout_q    <= 1'b0;
            stall_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            beat_count_q <= beat_count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef AXIS_BURST_READER_TIMEOUT_EN
            timeout_q    <= timeout_d;
            stall_q      <= stall_d;
`endif
        end
    end

endmodule

// File: tb/tb_axis_burst_reader.sv
// Self-checking bench for axis_burst_reader: queue-based FIFO and scoreboard model,
// directed bursts with literal expectations, then randomized bursts.
module tb_axis_burst_reader;

    localparam int TW = 128;
    localparam int LW = 32;

    logic          aclk = 1'b0;
    logic          areset;
    logic          start;
    logic [LW-1:0] burst_len;
    logic          busy;
    logic          done;
    logic [LW-1:0] beat_count;
    logic          timeout;
    logic [TW-1:0] S_AXIS_TDATA;
    logic          S_AXIS_TVALID;
    logic          S_AXIS_TREADY;
    logic [TW-1:0] M_AXIS_TDATA;
    logic          M_AXIS_TVALID;
    logic          M_AXIS_TLAST;
    logic          M_AXIS_TREADY;

    always #5 aclk = ~aclk;

    axis_burst_reader #(
        .TDATA_WIDTH    (TW),
        .LEN_WIDTH      (LW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .start         (start),
        .burst_len     (burst_len),
        .busy          (busy),
        .done          (done),
        .beat_count    (beat_count),
        .timeout       (timeout),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TREADY (M_AXIS_TREADY)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Stimulus controls
    logic [TW-1:0] fifo[$];
    bit            drv_reset;
    bit            drv_start;
    logic [LW-1:0] drv_len;
    int            gap_pct;
    int            rdy_pct;
    bit            rdy_toggle;

    // Reference model
    bit            m_busy, m_done, m_relax;
    int            m_len, m_reads, m_deliv, m_beats;
    logic [TW-1:0] exp_data[$];
    bit            exp_last[$];
    bit            prev_valid, prev_ready, prev_last, prev_in_hs;
    logic [TW-1:0] prev_data;
    int            out_cycles[$];
    int            done_cycles[$];
    int            n_lasts;

    task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_len = 0; m_reads = 0; m_deliv = 0; m_beats = 0;
        exp_data.delete(); exp_last.delete();
        prev_valid = 0; prev_ready = 0; prev_last = 0; prev_in_hs = 0; prev_data = '0;
    endtask

    // One clock cycle: drive inputs at negedge, compare outputs, advance the model.
    task automatic step();
        bit in_hs, out_hs, acc, nxt_done, allowed;
        int r0, d0;
        @(negedge aclk);
        cyc++;
        areset    = drv_reset;
        start     = drv_start;
        burst_len = drv_len;
        drv_start = 0;
        S_AXIS_TVALID = (fifo.size() > 0) && ($urandom_range(99) >= gap_pct);
        S_AXIS_TDATA  = (fifo.size() > 0) ? fifo[0] : '0;
        M_AXIS_TREADY = rdy_toggle ? (cyc % 2 == 0) : ($urandom_range(99) < rdy_pct);
        #1;
        in_hs  = S_AXIS_TVALID && (S_AXIS_TREADY === 1'b1);
        out_hs = (M_AXIS_TVALID === 1'b1) && M_AXIS_TREADY;
        if (in_hs) void'(fifo.pop_front());
        if (drv_reset) begin
            model_reset();
            return;
        end
        r0 = m_reads;
        d0 = m_deliv;
        allowed = m_busy && !m_done && (m_reads < m_len);

        if (!m_relax) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
        end
        chk("beat_count", beat_count, m_beats);
`ifndef AXIS_BURST_READER_TIMEOUT_EN
        chk("timeout_tied", timeout, 0);
`endif
        if (S_AXIS_TREADY !== 1'b0) chk("s_tready_allowed", allowed, 1);
        if (prev_in_hs) chk("m_tvalid_latency", M_AXIS_TVALID, 1);
        if (prev_valid && !prev_ready) begin
            chk("stall_valid_held", M_AXIS_TVALID, 1);
            chk("stall_tdata_stable", M_AXIS_TDATA, prev_data);
            chk("stall_tlast_stable", M_AXIS_TLAST, prev_last);
        end
        if (M_AXIS_TVALID !== 1'b0) chk("m_tvalid_in_burst", m_busy, 1);

        if (out_hs) begin
            if (exp_data.size() == 0) begin
                chk("spurious_beat", 1, 0);
            end else begin
                chk("m_tdata", M_AXIS_TDATA, exp_data.pop_front());
                chk("m_tlast", M_AXIS_TLAST, exp_last.pop_front());
            end
            m_deliv++;
            m_beats++;
            out_cycles.push_back(cyc);
            if (M_AXIS_TLAST) n_lasts++;
        end
        if (in_hs) begin
            m_reads++;
            exp_data.push_back(S_AXIS_TDATA);
            exp_last.push_back(m_reads == m_len);
        end
        if (done === 1'b1) done_cycles.push_back(cyc);

        nxt_done = 0;
        acc = start && !m_busy;
        if (m_relax) begin
            if (done === 1'b1) m_busy = 0;
        end else begin
            if (m_busy && !m_done && m_len != 0 && r0 == m_len && d0 == m_len) nxt_done = 1;
            if (m_done) m_busy = 0;
        end
        if (acc) begin
            m_busy = 1; m_len = int'(burst_len);
            m_reads = 0; m_deliv = 0; m_beats = 0;
            exp_data.delete(); exp_last.delete();
            if (burst_len == 0 && !m_relax) nxt_done = 1;
        end
        m_done     = nxt_done;
        prev_valid = (M_AXIS_TVALID === 1'b1);
        prev_ready = M_AXIS_TREADY;
        prev_data  = M_AXIS_TDATA;
        prev_last  = M_AXIS_TLAST;
        prev_in_hs = in_hs;
    endtask

    task automatic run_burst(input int len, input int extra, input int poke_at, output int start_cyc);
        int n;
        for (int i = 0; i < len + extra; i++) fifo.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
        out_cycles.delete();
        done_cycles.delete();
        n_lasts   = 0;
        drv_start = 1;
        drv_len   = LW'(len);
        step();
        start_cyc = cyc;
        n = 0;
        while (m_busy && n < 3000) begin
            if (n == poke_at) begin
                drv_start = 1;
                drv_len   = LW'($urandom_range(5, 1));
            end
            step();
            n++;
        end
        chk("burst_completes", m_busy, 0);
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_beat_count"}, beat_count, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_s_tready"}, S_AXIS_TREADY, 0);
        chk({tag, "_m_tvalid"}, M_AXIS_TVALID, 0);
        chk({tag, "_m_tlast"}, M_AXIS_TLAST, 0);
    endtask

    initial begin
        int c0, n;
        areset = 1; start = 0; burst_len = '0;
        S_AXIS_TVALID = 0; S_AXIS_TDATA = '0; M_AXIS_TREADY = 0;
        drv_reset = 1; drv_start = 0; drv_len = '0;
        gap_pct = 0; rdy_pct = 100; rdy_toggle = 0; m_relax = 0;
        model_reset();
        repeat (3) step();
        drv_reset = 0;
        step();
        check_idle_zero("reset");

        // 8 beats back to back; a start mid-burst must be ignored
        run_burst(8, 0, 4, c0);
        chk("t1_beats", out_cycles.size(), 8);
        if (out_cycles.size() == 8) begin
            chk("t1_first_beat_cycle", out_cycles[0], c0 + 2);
            chk("t1_last_beat_cycle", out_cycles[7], c0 + 9);
        end
        chk("t1_done_count", done_cycles.size(), 1);
        if (done_cycles.size() == 1) chk("t1_done_cycle", done_cycles[0], c0 + 11);
        chk("t1_tlast_count", n_lasts, 1);
        chk("t1_beat_count", beat_count, 8);

        // Only 4 of 10 FIFO words consumed
        run_burst(4, 6, -1, c0);
        chk("t2_fifo_left", fifo.size(), 6);
        chk("t2_beat_count", beat_count, 4);
        fifo.delete();

        // Alternating downstream ready
        rdy_toggle = 1;
        run_burst(16, 0, 7, c0);
        rdy_toggle = 0;
        chk("t3_beats", out_cycles.size(), 16);
        chk("t3_beat_count", beat_count, 16);

        // Zero-length burst
        run_burst(0, 0, 0, c0);
        chk("t4_done_count", done_cycles.size(), 1);
        if (done_cycles.size() == 1) chk("t4_done_cycle", done_cycles[0], c0 + 1);
        chk("t4_beats", out_cycles.size(), 0);
        chk("t4_beat_count", beat_count, 0);

        // Reset in the middle of a burst
        for (int i = 0; i < 8; i++) fifo.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
        drv_start = 1; drv_len = 8;
        step();
        n = 0;
        while (m_deliv < 3 && n < 100) begin step(); n++; end
        chk("t5_three_beats", m_deliv, 3);
        drv_reset = 1;
        step();
        drv_reset = 0;
        step();
        check_idle_zero("t5_post_reset");
        fifo.delete();
        run_burst(2, 0, -1, c0);
        chk("t5_fresh_beats", out_cycles.size(), 2);
        chk("t5_fresh_beat_count", beat_count, 2);
        chk("t5_fresh_done", done_cycles.size(), 1);

        // Randomized bursts
        for (int b = 0; b < 25; b++) begin
            gap_pct = $urandom_range(60, 0);
            rdy_pct = $urandom_range(100, 30);
            run_burst($urandom_range(24, 1), $urandom_range(3, 0), $urandom_range(12, 0), c0);
            chk("rand_done_count", done_cycles.size(), 1);
            chk("rand_tlast_count", n_lasts, 1);
            n = $urandom_range(3, 0);
            repeat (n) step();
        end
        gap_pct = 0; rdy_pct = 100;

`ifdef AXIS_BURST_READER_TIMEOUT_EN
        // Supply 5 of 8 words; the stall limit ends the burst early
        fifo.delete();
        m_relax = 1;
        for (int i = 0; i < 5; i++) fifo.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
        out_cycles.delete(); done_cycles.delete(); n_lasts = 0;
        drv_start = 1; drv_len = 8;
        step();
        n = 0;
        while (m_busy && n < 300) begin step(); n++; end
        chk("t6_finished", m_busy, 0);
        chk("t6_beats", out_cycles.size(), 5);
        chk("t6_tlast_count", n_lasts, 0);
        chk("t6_timeout", timeout, 1);
        chk("t6_done_count", done_cycles.size(), 1);
        m_relax = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
